// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter
// Bytes are pushed into a small FIFO and serialized back-to-back.
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send_enable,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       busy,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [15:0]   BIT_END = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [15:0]     baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q, overflow_q;
   logic            push, pop, bit_end, fifo_nonempty;

   // A write is judged against the registered full flag, even if a pop happens on the same edge.
   assign push          = send_enable & ~full_q;
   assign fifo_nonempty = (count_q != '0);
   assign bit_end       = (baud_q == BIT_END);
   assign count_d       = count_q + CW'(push) - CW'(pop);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         if (send_enable && full_q) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      if (state_q != IDLE) begin
         baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
      end
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (fifo_nonempty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               tx_d    = 1'b0;
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q != 3'd7) begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end else begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            // Chain straight into the next start bit so queued frames have no idle gap.
            if (bit_end) begin
               if (fifo_nonempty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx        = tx_q;
   assign busy      = (state_q != IDLE) || fifo_nonempty;
   assign fifo_full = full_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered
// A background receiver decodes every 8N1 frame into a queue.
module tb_uart_tx_buffered;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       send_enable = 1'b0;
   logic [7:0] data_in = '0;
   logic       tx, busy, fifo_full, overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int frame_errs = 0;
   logic [7:0] rx_q [$];
   int         rx_t [$];

   uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .send_enable(send_enable), .data_in(data_in),
      .tx(tx), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sample at the middle of each 4-cycle bit; frames overlapping a reset are discarded.
   initial begin : monitor
      int t0;
      logic ab, fe;
      logic [7:0] d;
      forever begin
         @(negedge clk);
         if (!reset && tx === 1'b0) begin
            t0 = cyc; ab = 1'b0; fe = 1'b0; d = '0;
            repeat (2) @(negedge clk);
            ab |= reset;
            if (tx !== 1'b0) fe = 1'b1;
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge clk);
               ab |= reset;
               d[i] = tx;
            end
            repeat (4) @(negedge clk);
            ab |= reset;
            if (tx !== 1'b1) fe = 1'b1;
            if (!ab) begin
               rx_q.push_back(d);
               rx_t.push_back(t0);
               if (fe) frame_errs++;
            end
         end
      end
   end

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      send_enable = 1'b1;
      data_in     = b;
   endtask

   task automatic idle();
      @(negedge clk);
      send_enable = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input int n);
      int budget = 0;
      while (rx_q.size() < n && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      check_eq(tag, rx_q.size(), n);
   endtask

   task automatic wait_idle(input string tag);
      int budget = 0;
      while (busy !== 1'b0 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      repeat (3) @(negedge clk);
      check_eq(tag, busy, 1'b0);
   endtask

   task automatic check_rx(input string tag, input logic [7:0] exp);
      logic [8:0] got;
      got = (rx_q.size() > 0) ? {1'b0, rx_q.pop_front()} : 9'h100;
      check_eq(tag, got, {1'b0, exp});
   endtask

   initial begin
      logic [39:0] cap, exp_wave;
      logic [7:0]  b;
      int          bad, t_a, t_b, k;
      int          gap [12] = '{0, 40, 40, 40, 0, 0, 40, 40, 40, 0, 0, 40};

      repeat (3) @(negedge clk);
      check_eq("rst_tx", tx, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_full", fifo_full, 1'b0);
      check_eq("rst_ovf", overflow, 1'b0);
      reset = 1'b0;

      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b0) bad++;
      end
      check_eq("idle_outputs", bad, 0);
      check_eq("idle_no_frames", rx_q.size(), 0);

      // Single byte 0xA5: exact per-cycle waveform
      b = 8'hA5;
      for (int i = 0; i < 40; i++) begin
         k = i / 4;
         exp_wave[i] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      end
      push(b);
      idle();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cap[i] = tx;
      end
      check_eq("a5_wave", cap, exp_wave);
      check_eq("a5_busy_k40", busy, 1'b1);
      @(negedge clk);
      check_eq("a5_busy_k41", busy, 1'b0);
      check_eq("a5_tx_idle", tx, 1'b1);
      check_rx("a5_rx", 8'hA5);

      // Back-to-back frames
      rx_q.delete(); rx_t.delete();
      push(8'h01);
      push(8'h80);
      idle();
      wait_frames("b2b_count", 2);
      t_a = rx_t[0];
      t_b = rx_t[1];
      check_eq("b2b_period", t_b - t_a, 40);
      check_rx("b2b_rx0", 8'h01);
      check_rx("b2b_rx1", 8'h80);
      wait_idle("b2b_idle");

      // Overflow: six consecutive writes into a depth-4 FIFO
      rx_q.delete(); rx_t.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 4) check_eq("ovf_full_after4", fifo_full, 1'b0);
         if (i == 5) check_eq("ovf_full_after5", fifo_full, 1'b1);
         if (i == 5) check_eq("ovf_flag_before6", overflow, 1'b0);
         send_enable = 1'b1;
         data_in     = 8'h10 + 8'(i);
      end
      idle();
      check_eq("ovf_flag", overflow, 1'b1);
      check_eq("ovf_full_held", fifo_full, 1'b1);
      wait_frames("ovf_count", 5);
      wait_idle("ovf_idle");
      check_eq("ovf_exact5", rx_q.size(), 5);
      for (int i = 0; i < 5; i++) check_rx("ovf_rx", 8'h10 + 8'(i));
      check_eq("ovf_sticky", overflow, 1'b1);

      // Reset during DATA bit 3 of 0x3C with two bytes queued
      rx_q.delete(); rx_t.delete();
      push(8'h3C);
      push(8'hAA);
      push(8'hBB);
      idle();
      repeat (16) @(negedge clk);
      check_eq("rst_mid_busy_pre", busy, 1'b1);
      #1 reset = 1'b1;
      #1;
      check_eq("rst_mid_tx", tx, 1'b1);
      check_eq("rst_mid_busy", busy, 1'b0);
      repeat (5) @(negedge clk);
      check_eq("rst_mid_full", fifo_full, 1'b0);
      check_eq("rst_mid_ovf", overflow, 1'b0);
      reset = 1'b0;
      repeat (45) @(negedge clk);
      check_eq("rst_mid_flushed", rx_q.size(), 0);
      check_eq("rst_mid_idle", busy, 1'b0);
      push(8'h55);
      idle();
      wait_frames("post_rst_count", 1);
      check_rx("post_rst_rx", 8'h55);
      wait_idle("post_rst_idle");

      // Wrap-around: singles spaced one frame apart mixed with bursts of three
      rx_q.delete(); rx_t.delete();
      for (int i = 0; i < 12; i++) begin
         if (gap[i] > 0) begin
            idle();
            repeat (gap[i] - 1) @(negedge clk);
         end
         push(8'(i * 17 + 3));
      end
      idle();
      wait_frames("wrap_count", 12);
      wait_idle("wrap_idle");
      for (int i = 0; i < 12; i++) check_rx("wrap_rx", 8'(i * 17 + 3));
      check_eq("wrap_ovf", overflow, 1'b0);
      check_eq("frame_errors", frame_errs, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Synthesizable replacement for the simulation-only UART print stage. It consumes the CPU's accumulator byte on a one-cycle send strobe and buffers it in a small FIFO. It then serializes each byte onto a single 8N1 UART line (start bit, 8 data bits LSB first, 1 stop bit). It sits directly downstream of the ACC/output-enable logic and drives the board TX pin.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
FIFO_DEPTH, 4, byte entries in the TX FIFO; power of two, 2..16.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
send_enable  input  1  write strobe; each cycle it is high pushes data_in (one byte per cycle).
data_in  input  8  byte to transmit (from ACC).
tx  output  1  serial line; idles high; registered output.
busy  output  1  high while the FIFO is non-empty or a frame is in progress.
fifo_full  output  1  registered; FIFO holds FIFO_DEPTH bytes.
overflow  output  1  sticky; set when a write is dropped because the FIFO is full.

Behaviour:
- Reset (async, takes effect immediately): tx=1, busy=0, fifo_full=0, overflow=0. FIFO pointers and count go to 0, FSM goes to IDLE, bit and baud counters go to 0. Reset mid-frame aborts the frame with tx high at once; buffered bytes are discarded.
- Write rule: on an edge with send_enable=1:
  - if fifo_full (registered value, before any same-edge pop) is 0, data_in is stored;
  - otherwise the byte is dropped and overflow is set to 1.
  - overflow clears only on reset.
- Simultaneous push and pop on one edge: count is unchanged, both operations take effect. A push while full is still rejected even if a pop occurs on the same edge.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state; "bit end" means the counter equals CLKS_PER_BIT-1.
  - IDLE: tx=1. If FIFO non-empty: pop the head into the shift register, set tx<=0, go to START, baud counter <= 0.
  - START: at bit end, tx<=shift[0], bit index <= 0, go to DATA.
  - DATA: at bit end, if bit index < 7: shift right, tx<=next bit, increment index. At index 7: tx<=1, go to STOP.
  - STOP: at bit end, if FIFO non-empty: pop, tx<=0, go to START (no idle gap between frames). Otherwise go to IDLE.
- Latency: a byte written at edge k into an empty FIFO while in IDLE is popped at edge k+1. tx is low from edge k+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have a period of exactly 10*CLKS_PER_BIT.
- busy = (state != IDLE) or (count != 0). It is combinational from registered state.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- data_in is ignored when send_enable=0. send_enable is meaningless during reset.

Test Plan:
- Idle after reset (CLKS_PER_BIT=4): hold send_enable=0 for 100 cycles -> tx=1, busy=0, fifo_full=0, overflow=0 throughout.
- Single byte 0xA5 (CLKS_PER_BIT=4), strobe at edge k -> tx from edge k+1 holds, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1. busy drops after edge k+41.
- Back-to-back 0x01 then 0x80 on consecutive cycles -> two contiguous frames totalling 80 cycles with no idle gap. Decoded bytes are 0x01, 0x80; the second start bit begins exactly 40 cycles after the first.
- Overflow (FIFO_DEPTH=4): six writes 0x10..0x15 on consecutive cycles -> 0x10 popped at once, fifo_full rises after the 5th write, 0x15 dropped, overflow=1. Exactly 0x10..0x14 appear on tx in order.
- Reset mid-frame: assert reset during DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 immediately, busy=0, FIFO empty. After release a new 0x55 transmits correctly.
- Wrap-around: stream 12 bytes, writing 1 byte every 10*CLKS_PER_BIT cycles plus bursts of 3 -> all bytes received in order, pointers wrap at least twice, overflow stays 0.
